// File: rtl/dsp_pkg.sv
// Shared DSP packet word layout and block-averager state encoding.
// The rectifier stage uses the same layout constants.
package dsp_pkg;

  localparam int SOF_BIT = 13;
  localparam int OVF_BIT = 12;
  localparam int ADC_W   = 12;
  localparam int PKT_W   = 14;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACCUM    = 1'b1
  } state_t;

endpackage

// File: rtl/dsp_block_averager.sv
// Averages blocks of 2^LOG2_LEN rectified samples aligned to packet SoF,
// emitting truncated mean, peak magnitude and sticky flags per block.
module dsp_block_averager
  import dsp_pkg::*;
#(
  parameter int LOG2_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic [PKT_W-1:0] i_data,
  input  logic             i_valid,
  output logic [PKT_W-1:0] o_data,
  output logic [ADC_W-1:0] o_peak,
  output logic             o_valid,
  output logic             o_partial
);

  localparam int ACC_W = ADC_W + LOG2_LEN;
  localparam logic [LOG2_LEN-1:0] LAST_CNT = '1;

  state_t state, state_nx;

  logic [ACC_W-1:0]    acc, acc_nx, sum;
  logic [LOG2_LEN-1:0] cnt, cnt_nx;
  logic [ADC_W-1:0]    pk, pk_nx, pk_max, mag;
  logic                ovf, ovf_nx, ovf_any;
  logic                sof, sof_nx;
  logic                in_sof, in_ovf;
  logic                emit, partial;

  assign mag     = i_data[ADC_W-1:0];
  assign in_sof  = i_data[SOF_BIT];
  assign in_ovf  = i_data[OVF_BIT];
  assign sum     = acc + ACC_W'(mag);
  assign pk_max  = (mag > pk) ? mag : pk;
  assign ovf_any = ovf | in_ovf;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= WAIT_SOF;
    else         state <= state_nx;
  end

  // An SoF always restarts the block; any samples already counted are dropped.
  always_comb begin
    state_nx = state;
    acc_nx   = acc;
    cnt_nx   = cnt;
    pk_nx    = pk;
    ovf_nx   = ovf;
    sof_nx   = sof;
    emit     = 1'b0;
    partial  = 1'b0;
    if (i_valid) begin
      if (in_sof) begin
        state_nx = ACCUM;
        acc_nx   = ACC_W'(mag);
        pk_nx    = mag;
        ovf_nx   = in_ovf;
        sof_nx   = 1'b1;
        cnt_nx   = LOG2_LEN'(1);
        partial  = (state == ACCUM) && (cnt != '0);
      end else if (state == ACCUM) begin
        if (cnt == LAST_CNT) begin
          emit   = 1'b1;
          acc_nx = '0;
          pk_nx  = '0;
          ovf_nx = 1'b0;
          sof_nx = 1'b0;
          cnt_nx = '0;
        end else begin
          acc_nx = sum;
          pk_nx  = pk_max;
          ovf_nx = ovf_any;
          cnt_nx = cnt + LOG2_LEN'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      acc       <= '0;
      cnt       <= '0;
      pk        <= '0;
      ovf       <= 1'b0;
      sof       <= 1'b0;
      o_data    <= '0;
      o_peak    <= '0;
      o_valid   <= 1'b0;
      o_partial <= 1'b0;
    end else begin
      acc       <= acc_nx;
      cnt       <= cnt_nx;
      pk        <= pk_nx;
      ovf       <= ovf_nx;
      sof       <= sof_nx;
      o_valid   <= emit;
      o_partial <= partial;
      // Summary is taken from the pre-clear running values plus the final sample.
      if (emit) begin
        o_data <= {sof, ovf_any, sum[LOG2_LEN +: ADC_W]};
        o_peak <= pk_max;
      end
    end
  end

endmodule

// File: tb/tb_dsp_block_averager.sv
// Self-checking bench for dsp_block_averager: directed vector table,
// reset sequence, then randomized traffic against a queue-based model.
module tb_dsp_block_averager;

  localparam int LOG2_LEN = 4;
  localparam int N        = 1 << LOG2_LEN;

  logic        i_clk;
  logic        i_rstn;
  logic [13:0] i_data;
  logic        i_valid;
  logic [13:0] o_data;
  logic [11:0] o_peak;
  logic        o_valid;
  logic        o_partial;

  dsp_block_averager #(.LOG2_LEN(LOG2_LEN)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_data   (i_data),
    .i_valid  (i_valid),
    .o_data   (o_data),
    .o_peak   (o_peak),
    .o_valid  (o_valid),
    .o_partial(o_partial)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    bit          valid;
    bit          sof;
    bit          ovf;
    logic [11:0] mag;
    bit          expValid;
    bit          expPartial;
    logic [13:0] expData;
    logic [11:0] expPeak;
  } vec_t;

  vec_t        vecs[$];
  logic [13:0] holdData;
  logic [11:0] holdPeak;

  // Reference model: the current block is just a list of magnitudes.
  bit          mInBlock;
  int          mMags[$];
  bit          mOvf;
  bit          mFirst;
  bit          mValid;
  bit          mPartial;
  logic [13:0] mData;
  logic [11:0] mPeak;

  function automatic void modelReset();
    mInBlock = 0;
    mMags.delete();
    mOvf = 0; mFirst = 0; mValid = 0; mPartial = 0;
    mData = '0; mPeak = '0;
  endfunction

  function automatic void modelStep(bit v, bit s, bit o, logic [11:0] m);
    int sum;
    int mx;
    mValid = 0;
    mPartial = 0;
    if (!v) return;
    if (s) begin
      if (mInBlock && mMags.size() != 0) mPartial = 1;
      mMags.delete();
      mMags.push_back(int'(m));
      mOvf = o; mFirst = 1; mInBlock = 1;
    end else if (mInBlock) begin
      mMags.push_back(int'(m));
      mOvf = mOvf | o;
      if (mMags.size() == N) begin
        sum = 0; mx = 0;
        foreach (mMags[k]) begin
          sum += mMags[k];
          if (mMags[k] > mx) mx = mMags[k];
        end
        mData  = {mFirst, mOvf, 12'(sum / N)};
        mPeak  = 12'(mx);
        mValid = 1;
        mMags.delete();
        mOvf = 0; mFirst = 0;
      end
    end
  endfunction

  function automatic void addVec(bit v, bit s, bit o, logic [11:0] m, bit ev, bit ep,
                                 logic [13:0] d, logic [11:0] p);
    vec_t x;
    if (ev) begin holdData = d; holdPeak = p; end
    x.valid = v; x.sof = s; x.ovf = o; x.mag = m;
    x.expValid = ev; x.expPartial = ep; x.expData = holdData; x.expPeak = holdPeak;
    vecs.push_back(x);
  endfunction

  function automatic void addPlain(bit v, bit s, bit o, logic [11:0] m);
    addVec(v, s, o, m, 0, 0, '0, '0);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic checkOutput(string tag, bit ev, bit ep, logic [13:0] ed, logic [11:0] epk);
    check({tag, " o_valid"},   32'(o_valid),   32'(ev));
    check({tag, " o_partial"}, 32'(o_partial), 32'(ep));
    check({tag, " o_data"},    32'(o_data),    32'(ed));
    check({tag, " o_peak"},    32'(o_peak),    32'(epk));
  endtask

  task automatic applyStimulus(bit v, bit s, bit o, logic [11:0] m);
    @(negedge i_clk);
    i_valid = v;
    i_data  = {s, o, m};
    @(posedge i_clk);
    #1;
    modelStep(v, s, o, m);
  endtask

  initial begin
    i_valid = 1'b0;
    i_data  = '0;
    i_rstn  = 1'b0;
    holdData = '0;
    holdPeak = '0;
    modelReset();
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("reset", 0, 0, 14'h0000, 12'h000);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Samples before any SoF are ignored.
    for (int k = 0; k < 3; k++) addPlain(1, 0, 0, 12'd500);
    // SoF + 15 x 100.
    addPlain(1, 1, 0, 12'd100);
    for (int k = 1; k < N - 1; k++) addPlain(1, 0, 0, 12'd100);
    addVec(1, 0, 0, 12'd100, 1, 0, 14'h2064, 12'd100);
    // Block without SoF, magnitudes 0..15.
    for (int k = 0; k < N - 1; k++) addPlain(1, 0, 0, 12'(k));
    addVec(1, 0, 0, 12'd15, 1, 0, 14'h0007, 12'd15);
    // 16 x full-scale with i_valid gaps, SoF at cnt==0 gives no partial.
    addPlain(1, 1, 0, 12'h800);
    for (int k = 1; k < N - 1; k++) begin
      addPlain(0, 0, 0, 12'h000);
      addPlain(1, 0, 0, 12'h800);
    end
    addPlain(0, 0, 0, 12'h000);
    addVec(1, 0, 0, 12'h800, 1, 0, 14'h2800, 12'h800);
    addPlain(0, 0, 0, 12'h000);
    // Overflow on the 5th sample only, then a clean block.
    for (int k = 0; k < N - 1; k++) addPlain(1, 0, (k == 4), 12'd10);
    addVec(1, 0, 0, 12'd10, 1, 0, 14'h100A, 12'd10);
    for (int k = 0; k < N - 1; k++) addPlain(1, 0, 0, 12'd20);
    addVec(1, 0, 0, 12'd20, 1, 0, 14'h0014, 12'd20);
    // SoF after 9 samples discards them.
    for (int k = 0; k < 9; k++) addPlain(1, 0, 0, 12'd50);
    addVec(1, 1, 0, 12'd30, 0, 1, '0, '0);
    for (int k = 1; k < N - 1; k++) addPlain(1, 0, 0, 12'd30);
    addVec(1, 0, 0, 12'd30, 1, 0, 14'h201E, 12'd30);
    // SoF on the Nth sample of a block.
    for (int k = 0; k < N - 1; k++) addPlain(1, 0, 0, 12'd7);
    addVec(1, 1, 0, 12'd9, 0, 1, '0, '0);
    for (int k = 1; k < N - 1; k++) addPlain(1, 0, 0, 12'd9);
    addVec(1, 0, 0, 12'd9, 1, 0, 14'h2009, 12'd9);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].valid, vecs[k].sof, vecs[k].ovf, vecs[k].mag);
      checkOutput($sformatf("vec%0d", k), vecs[k].expValid, vecs[k].expPartial,
                  vecs[k].expData, vecs[k].expPeak);
    end

    // Mid-block asynchronous reset clears outputs without a clock edge.
    applyStimulus(1, 1, 0, 12'd200);
    for (int k = 0; k < 4; k++) applyStimulus(1, 0, 0, 12'd200);
    @(negedge i_clk);
    i_valid = 1'b0;
    #2;
    i_rstn = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 14'h0000, 12'h000);
    modelReset();
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 1, 12'd300);
      checkOutput($sformatf("post_reset_ignore%0d", k), 0, 0, 14'h0000, 12'h000);
    end
    applyStimulus(1, 1, 0, 12'd64);
    checkOutput("post_reset_sof", 0, 0, 14'h0000, 12'h000);
    for (int k = 1; k < N - 1; k++) applyStimulus(1, 0, 0, 12'd64);
    applyStimulus(1, 0, 0, 12'd64);
    checkOutput("post_reset_block", 1, 0, 14'h2040, 12'd64);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 3000; k++) begin
      bit v, s, o;
      logic [11:0] m;
      int r;
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 39) == 0);
      o = ($urandom_range(0, 29) == 0);
      r = $urandom_range(0, 9);
      if (r == 0)      m = 12'h000;
      else if (r == 1) m = 12'h800;
      else             m = 12'($urandom_range(0, 2048));
      applyStimulus(v, s, o, m);
      checkOutput($sformatf("rnd%0d", k), mValid, mPartial, mData, mPeak);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dsp_block_averager.md
# dsp_block_averager

Reduces the rectified ADC stream to one summary word per block of 2^LOG2_LEN samples. Each summary carries the truncated mean magnitude, the block peak magnitude, and flags. The block sits directly downstream of the rectifier stage and consumes its 14-bit packet words. Block boundaries are aligned to the packet SoF flag.

## Interface
- LOG2_LEN, 4: log2 of block length N. Legal range is 1..8, so N = 2..256.
- i_clk  in  1  100MHz system clock.
- i_rstn  in  1  Reset; asynchronous and active-low.
- i_data  in  14  Rectified packet word:
  - [13] SoF.
  - [12] overflow.
  - [11:0] unsigned magnitude, 0..2048. 0x800 is +2048, not negative.
- i_valid  in  1  i_data valid this cycle. No backpressure.
- o_data  out  14  Block summary:
  - [13] first block after SoF.
  - [12] OR of the overflow flags of all N samples.
  - [11:0] mean = sum >> LOG2_LEN, truncated.
- o_peak  out  12  Maximum magnitude seen in the block.
- o_valid  out  1  One-cycle pulse; o_data and o_peak are valid.
- o_partial  out  1  One-cycle pulse; an incomplete block was discarded by an SoF.

## Operation
- Accepted sample: i_valid=1 on a rising edge. Cycles with i_valid=0 leave all state unchanged.
- Internal state:
  - Accumulator acc, ACC_W = 12+LOG2_LEN bits. Max sum 2048·N = 2^(11+LOG2_LEN), so it never wraps.
  - Sample counter cnt, LOG2_LEN bits.
  - Running peak pk, 12 bits.
  - Sticky overflow ovf.
  - First-block flag sof.
- State machine, 2 states:
  - WAIT_SOF, the reset state: accepted samples with SoF=0 are ignored. An accepted sample with SoF=1 initialises the block: acc=mag, pk=mag, ovf=i_data[12], sof=1, cnt=1. Then go to ACCUM.
  - ACCUM, non-SoF sample: acc+=mag, pk=max(pk,mag), ovf|=flag, cnt+=1.
  - ACCUM, sample that completes the block (cnt==N-1 before accept):
    - Register outputs from the combinational next values: mean=(acc+mag)>>LOG2_LEN, peak=max(pk,mag), ovf|flag, sof.
    - Pulse o_valid.
    - Clear acc, pk, ovf, sof and cnt. Stay in ACCUM.
  - ACCUM, accepted SoF=1 sample while cnt≠0:
    - Discard the partial block and pulse o_partial.
    - The SoF sample starts a new block exactly as in WAIT_SOF (cnt=1, sof=1).
    - o_valid stays 0.
  - ACCUM, SoF=1 with cnt==0: starts the block normally. No o_partial.
  - SoF on the Nth sample of a block: treated as SoF. The partial block of N-1 samples is dropped (o_partial=1) and no summary is produced.
- Between pulses, o_data and o_peak hold their last values.
- The block never returns to WAIT_SOF except via reset.

## Timing
- Reset values, applied immediately on the i_rstn falling edge:
  - o_data=0, o_peak=0, o_valid=0, o_partial=0.
  - acc, cnt, pk, ovf, sof all 0.
  - State = WAIT_SOF.
- Latency: o_valid is high in the cycle after the edge that accepts the Nth sample (1 cycle).
- Throughput: one sample per cycle, sustained. Back-to-back blocks give an o_valid pulse every N cycles with no gap cycle.
- o_valid and o_partial are never high in the same cycle.
- Reset asserted mid-block: the partial block is lost with no o_partial, and the block waits for the next SoF.
- Reset deassertion is assumed synchronised externally.

## Structure
- Shared package dsp_pkg holds:
  - Word layout constants: SOF_BIT=13, OVF_BIT=12, ADC_W=12, PKT_W=14. The rectifier uses the same constants.
  - State enum: WAIT_SOF, ACCUM.
- Single module with no sub-module. Counter, accumulator and peak compare are each a few lines.

## Test plan
- LOG2_LEN=4. SoF sample of 100, then 15 more samples of 100 → one o_valid. o_data=0x2064 (sof=1, ovf=0, mean 100), o_peak=100.
- Next block without SoF, magnitudes 0..15 → o_data=0x0007 (sum 120 truncated to 7), o_peak=15, bit13=0.
- 16 samples of 0x800 after SoF, with i_valid gaps between them → mean 0x800, o_peak=0x800, no wrap. o_valid comes 1 cycle after the last accept.
- Overflow flag on sample 5 only → that summary has bit12=1. The following block has bit12=0.
- SoF after 9 samples of a block → o_partial pulses, no o_valid. Counting restarts from the SoF sample, and the next summary follows 15 further samples with bit13=1.
- Samples before the first SoF are ignored (no output). An async reset pulse mid-block zeroes all outputs immediately, with no o_partial, and the block waits for SoF.
